// File: rtl/enc_16_4_seq.sv
// enc_16_4_seq: sequential 16-to-4 encoder.
// Accepts a 16-bit request vector over valid/ready and emits the 4-bit index
// of every set bit, one per output beat, lowest-first or highest-first.
// An all-zero vector produces a single beat flagged with out_none.
module enc_16_4_seq #(
  parameter int LSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_vec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_idx,
  output logic        out_last,
  output logic        out_none,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    EMPTY = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] pending_reg, pending_next;
  logic [15:0] clr_mask;
  logic [3:0]  enc_idx;
  logic        one_hot;

  // Priority encoder over the pending bits; direction chosen by LSB_FIRST.
  // The later match in each loop wins, so the scan order picks the priority.
  always_comb begin
    enc_idx = 4'd0;
    if (LSB_FIRST != 0) begin
      for (int i = 15; i >= 0; i--) begin
        if (pending_reg[i]) enc_idx = 4'(i);
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (pending_reg[i]) enc_idx = 4'(i);
      end
    end
  end

  // Exactly one bit left means the current beat is the final one.
  assign one_hot = (pending_reg != 16'd0) &&
                   ((pending_reg & (pending_reg - 16'd1)) == 16'd0);

  // One-hot mask of the bit retired by the current beat.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_clr
      assign clr_mask[gi] = (enc_idx == 4'(gi));
    end
  endgenerate

  // State and pending registers; reset discards any partially emitted vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pending_reg <= 16'd0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
    end
  end

  // Next-state and pending update from the handshakes.
  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          pending_next = in_vec;
          state_next   = (in_vec != 16'd0) ? EMIT : EMPTY;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pending_next = pending_reg & ~clr_mask;
          if (one_hot) state_next = IDLE;
        end
      end
      EMPTY: begin
        if (out_ready) state_next = IDLE;
      end
      default: begin
        state_next   = IDLE;
        pending_next = 16'd0;
      end
    endcase
  end

  // Outputs decode only from registered state, so a stalled beat stays stable.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = 4'd0;
    out_last  = 1'b0;
    out_none  = 1'b0;
    busy      = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        // Held off while reset is asserted so nothing looks acceptable then.
        in_ready = rst_n;
      end
      EMIT: begin
        out_valid = 1'b1;
        out_idx   = enc_idx;
        out_last  = one_hot;
      end
      EMPTY: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_none  = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_enc_16_4_seq.sv
// Bench for enc_16_4_seq: one instance per priority direction, shared stimulus.
module tb_enc_16_4_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_vec;
  logic        out_ready;

  logic        l_in_ready, l_out_valid, l_out_last, l_out_none, l_busy;
  logic [3:0]  l_out_idx;
  logic        m_in_ready, m_out_valid, m_out_last, m_out_none, m_busy;
  logic [3:0]  m_out_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  enc_16_4_seq #(.LSB_FIRST(1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_in_ready),
    .in_vec(in_vec), .out_valid(l_out_valid), .out_ready(out_ready),
    .out_idx(l_out_idx), .out_last(l_out_last), .out_none(l_out_none),
    .busy(l_busy)
  );

  enc_16_4_seq #(.LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_vec(in_vec), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_idx(m_out_idx), .out_last(m_out_last), .out_none(m_out_none),
    .busy(m_busy)
  );

  typedef struct {
    logic [15:0] vec;
    int          beats;
    logic [63:0] seq_lsb;  // nibble j = expected index of beat j, lowest-first
    logic [63:0] seq_msb;  // nibble j = expected index of beat j, highest-first
    logic        none;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Both instances idle with nothing on the output.
  task automatic chk_idle(input string tag);
    chk({tag, "_l_valid"}, 16'(l_out_valid), 16'd0);
    chk({tag, "_m_valid"}, 16'(m_out_valid), 16'd0);
    chk({tag, "_l_ready"}, 16'(l_in_ready), 16'd1);
    chk({tag, "_m_ready"}, 16'(m_in_ready), 16'd1);
    chk({tag, "_l_busy"},  16'(l_busy), 16'd0);
    chk({tag, "_m_busy"},  16'(m_busy), 16'd0);
  endtask

  // Check the current beat on both instances.
  task automatic chk_beat(input string tag, input logic [3:0] li, input logic [3:0] mi,
                          input logic last, input logic none);
    chk({tag, "_l_valid"}, 16'(l_out_valid), 16'd1);
    chk({tag, "_m_valid"}, 16'(m_out_valid), 16'd1);
    chk({tag, "_l_idx"},   16'(l_out_idx), 16'(li));
    chk({tag, "_m_idx"},   16'(m_out_idx), 16'(mi));
    chk({tag, "_l_last"},  16'(l_out_last), 16'(last));
    chk({tag, "_m_last"},  16'(m_out_last), 16'(last));
    chk({tag, "_l_none"},  16'(l_out_none), 16'(none));
    chk({tag, "_m_none"},  16'(m_out_none), 16'(none));
    chk({tag, "_l_inrdy"}, 16'(l_in_ready), 16'd0);
    chk({tag, "_m_busy"},  16'(m_busy), 16'd1);
  endtask

  // Accept one vector and drain it with out_ready held high.
  task automatic run_vec(input vec_t v);
    logic [63:0] sl, sm;
    sl = v.seq_lsb;
    sm = v.seq_msb;
    chk("accept_ready", 16'(l_in_ready), 16'd1);
    in_vec    = v.vec;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int j = 0; j < v.beats; j++) begin
      chk_beat("beat", sl[j*4 +: 4], sm[j*4 +: 4], (j == v.beats - 1), v.none);
      step();
    end
    chk_idle("after");
    $display("vec %h: %0d beats checked, errors so far %0d", v.vec, v.beats, errors);
  endtask

  initial begin
    tbl[0] = '{16'h0400, 1,  64'hA, 64'hA, 1'b0};
    tbl[1] = '{16'h8421, 4,  64'hFA50, 64'h05AF, 1'b0};
    tbl[2] = '{16'hFFFF, 16, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 1'b0};
    tbl[3] = '{16'h0000, 1,  64'h0, 64'h0, 1'b1};
    tbl[4] = '{16'h0003, 2,  64'h10, 64'h01, 1'b0};
    tbl[5] = '{16'h8000, 1,  64'hF, 64'hF, 1'b0};
    tbl[6] = '{16'h0001, 1,  64'h0, 64'h0, 1'b0};
    tbl[7] = '{16'h1248, 4,  64'hC963, 64'h369C, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = 16'd0;
    out_ready = 1'b0;
    #3;
    chk("rst_l_valid", 16'(l_out_valid), 16'd0);
    chk("rst_m_valid", 16'(m_out_valid), 16'd0);
    chk("rst_l_idx",   16'(l_out_idx), 16'd0);
    chk("rst_l_last",  16'(l_out_last), 16'd0);
    chk("rst_l_none",  16'(l_out_none), 16'd0);
    chk("rst_l_busy",  16'(l_busy), 16'd0);
    chk("rst_l_inrdy", 16'(l_in_ready), 16'd0);
    #10 rst_n = 1'b1;
    step();
    chk_idle("post_rst");

    for (int t = 0; t < 8; t++) run_vec(tbl[t]);

    // Backpressure: 0x0011 stalled for 5 cycles while a new vector is offered.
    in_vec    = 16'h0011;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_vec = 16'h8000;
    for (int c = 0; c < 5; c++) begin
      chk_beat("stall", 4'd0, 4'd4, 1'b0, 1'b0);
      chk("stall_m_inrdy", 16'(m_in_ready), 16'd0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk_beat("bp0", 4'd0, 4'd4, 1'b0, 1'b0);
    step();
    chk_beat("bp1", 4'd4, 4'd0, 1'b1, 1'b0);
    step();
    chk_idle("bp_done");
    step();
    chk_idle("bp_no_extra");
    $display("vec 0011 with stall: checked, errors so far %0d", errors);

    // Reset mid-EMIT with 0xFFFF partially emitted.
    in_vec   = 16'hFFFF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    chk_beat("pre_rst", 4'd3, 4'd12, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_l_valid", 16'(l_out_valid), 16'd0);
    chk("mrst_m_valid", 16'(m_out_valid), 16'd0);
    chk("mrst_l_busy",  16'(l_busy), 16'd0);
    chk("mrst_m_busy",  16'(m_busy), 16'd0);
    chk("mrst_l_idx",   16'(l_out_idx), 16'd0);
    in_valid = 1'b1;
    step();
    step();
    chk("mrst_hold_valid", 16'(l_out_valid), 16'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();
    chk_idle("mrst_rel");
    step();
    chk_idle("mrst_no_stale");
    $display("reset mid-emit: checked, errors so far %0d", errors);

    run_vec(tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
